// File: rtl/inst_fetcher_if.sv
// Fetch-stage bus bundle: memory request/response channel, dispatcher queue head and
// commit-side redirect.
interface inst_fetcher_if;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_req_ready;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_inst;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        pred_taken;
   logic        inst_ready;
   logic        flush;
   logic [31:0] flush_pc;

   modport master (
      output mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc, pred_taken,
      input  mem_req_ready, mem_resp_valid, mem_resp_inst, inst_ready, flush, flush_pc
   );

   modport slave (
      input  mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc, pred_taken,
      output mem_req_ready, mem_resp_valid, mem_resp_inst, inst_ready, flush, flush_pc
   );
endinterface

// File: rtl/inst_fetcher.sv
// Instruction fetch stage: one outstanding memory request, static backward-taken branch
// prediction and a circular instruction queue feeding the dispatcher.
module inst_fetcher #(
   parameter int unsigned IQ_DEPTH = 8,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input logic            clk,
   input logic            rst_n,
   inst_fetcher_if.master bus
);
   localparam int unsigned PtrW = $clog2(IQ_DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] Full = CntW'(IQ_DEPTH);

   typedef enum logic [1:0] {StFetch, StWait, StDrop} state_e;

   state_e          state_q, state_d;
   logic [31:0]     pc_q, pc_d;
   logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CntW-1:0] count_q, count_d;

   logic [31:0] iq_inst [IQ_DEPTH];
   logic [31:0] iq_pc   [IQ_DEPTH];
   logic        iq_pred [IQ_DEPTH];

   logic        push, pop, req_fire;
   logic [31:0] rinst, jal_imm, br_imm, next_pc;
   logic        pred;

   assign rinst   = bus.mem_resp_inst;
   assign jal_imm = {{11{rinst[31]}}, rinst[31], rinst[19:12], rinst[20], rinst[30:21], 1'b0};
   assign br_imm  = {{19{rinst[31]}}, rinst[31], rinst[7], rinst[30:25], rinst[11:8], 1'b0};

   always_comb begin
      next_pc = pc_q + 32'd4;
      pred    = 1'b0;
      if (rinst[6:0] == 7'b1101111) begin
         next_pc = pc_q + jal_imm;
         pred    = 1'b1;
      end else if (rinst[6:0] == 7'b1100011 && rinst[31]) begin
         next_pc = pc_q + br_imm;
         pred    = 1'b1;
      end
   end

   // Reset gates the request so nothing is offered to memory while rst_n is low.
   assign bus.mem_req_valid = rst_n && (state_q == StFetch) && (count_q < Full) && !bus.flush;
   assign bus.mem_req_addr  = pc_q;
   assign bus.inst_valid    = (count_q != '0);
   assign bus.inst          = bus.inst_valid ? iq_inst[head_q] : 32'h0;
   assign bus.inst_pc       = bus.inst_valid ? iq_pc[head_q]   : 32'h0;
   assign bus.pred_taken    = bus.inst_valid ? iq_pred[head_q] : 1'b0;

   assign req_fire = bus.mem_req_valid && bus.mem_req_ready;
   assign pop      = bus.inst_valid && bus.inst_ready && !bus.flush;
   assign push     = (state_q == StWait) && bus.mem_resp_valid && !bus.flush;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      head_d  = head_q + PtrW'(pop);
      tail_d  = tail_q + PtrW'(push);
      count_d = count_q + CntW'(push) - CntW'(pop);
      unique case (state_q)
         StFetch: if (req_fire) state_d = StWait;
         StWait: begin
            if (bus.mem_resp_valid) begin
               pc_d    = next_pc;
               state_d = StFetch;
            end
         end
         StDrop: if (bus.mem_resp_valid) state_d = StFetch;
         default: state_d = StFetch;
      endcase
      if (bus.flush) begin
         pc_d    = bus.flush_pc;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         // An outstanding request's response must still be swallowed after a redirect.
         if (state_q == StFetch || bus.mem_resp_valid) state_d = StFetch;
         else                                          state_d = StDrop;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StFetch;
         pc_q    <= RESET_PC;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         iq_inst[tail_q] <= rinst;
         iq_pc[tail_q]   <= pc_q;
         iq_pred[tail_q] <= pred;
      end
   end
endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: directed scenarios then randomized traffic, checked every cycle
// against a transaction-level model (queue of entries, outstanding/discard flags).
module tb_inst_fetcher;
   localparam int unsigned Depth = 8;
   localparam logic [31:0] ResetPc = 32'h0;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        pred;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n;
   inst_fetcher_if bus ();

   inst_fetcher #(.IQ_DEPTH(Depth), .RESET_PC(ResetPc)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   ent_t        mq[$];
   logic [31:0] m_pc;
   bit          m_out, m_disc;
   int          resp_wait;
   bit          cur_ready, cur_resp, cur_irdy, cur_fl, exp_fire;
   logic [31:0] cur_rinst, cur_fpc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Prediction rule computed as signed offsets assembled from the instruction fields.
   task automatic ref_predict(input logic [31:0] pc, input logic [31:0] w,
                              output logic [31:0] nxt, output logic taken);
      logic [31:0] off;
      nxt   = pc + 32'd4;
      taken = 1'b0;
      if (w[6:0] == 7'h6f) begin
         off = (w[31] ? 32'hFFF0_0000 : 32'h0) + (32'(w[19:12]) << 12)
               + (32'(w[20]) << 11) + (32'(w[30:21]) << 1);
         nxt   = pc + off;
         taken = 1'b1;
      end else if (w[6:0] == 7'h63 && w[31]) begin
         off = 32'hFFFF_F000 + (32'(w[7]) << 11) + (32'(w[30:25]) << 5) + (32'(w[11:8]) << 1);
         nxt   = pc + off;
         taken = 1'b1;
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_pc      = ResetPc;
      m_out     = 1'b0;
      m_disc    = 1'b0;
      resp_wait = 0;
   endtask

   // Drive one cycle's inputs (called just after a falling edge) and check all outputs.
   task automatic drive(input bit ready, input bit resp, input logic [31:0] rinst,
                        input bit irdy, input bit fl, input logic [31:0] fpc);
      bit exp_rv;
      cur_ready = ready; cur_resp = resp; cur_rinst = rinst;
      cur_irdy = irdy; cur_fl = fl; cur_fpc = fpc;
      bus.mem_req_ready  = ready;
      bus.mem_resp_valid = resp;
      bus.mem_resp_inst  = rinst;
      bus.inst_ready     = irdy;
      bus.flush          = fl;
      bus.flush_pc       = fpc;
      #1;
      exp_rv   = !m_out && (mq.size() < Depth) && !fl;
      exp_fire = exp_rv && ready;
      chk("mem_req_valid", 32'(bus.mem_req_valid), 32'(exp_rv));
      chk("mem_req_addr", bus.mem_req_addr, m_pc);
      chk("inst_valid", 32'(bus.inst_valid), 32'(mq.size() != 0));
      chk("inst", bus.inst, (mq.size() != 0) ? mq[0].inst : 32'h0);
      chk("inst_pc", bus.inst_pc, (mq.size() != 0) ? mq[0].pc : 32'h0);
      chk("pred_taken", 32'(bus.pred_taken), (mq.size() != 0) ? 32'(mq[0].pred) : 32'h0);
   endtask

   task automatic tick();
      logic [31:0] nxt;
      logic        tk;
      @(posedge clk);
      if (m_out && !cur_resp && resp_wait > 0) resp_wait--;
      if (cur_fl) begin
         mq.delete();
         if (m_out && cur_resp) begin
            m_out  = 1'b0;
            m_disc = 1'b0;
         end else if (m_out) begin
            m_disc = 1'b1;
         end
         m_pc = cur_fpc;
      end else begin
         if (mq.size() != 0 && cur_irdy) void'(mq.pop_front());
         if (m_out && cur_resp) begin
            if (!m_disc) begin
               ref_predict(m_pc, cur_rinst, nxt, tk);
               mq.push_back('{inst: cur_rinst, pc: m_pc, pred: tk});
               m_pc = nxt;
            end
            m_out  = 1'b0;
            m_disc = 1'b0;
         end
         if (exp_fire) begin
            m_out     = 1'b1;
            resp_wait = $urandom_range(0, 2);
         end
      end
      @(negedge clk);
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] r = $urandom;
      case ($urandom % 5)
         0:       return {r[31:7], 7'h13};
         1:       return {r[31:7], 7'h6f};
         2:       return {r[31:7], 7'h63};
         3:       return {r[31:7], 7'h67};
         default: return r;
      endcase
   endfunction

   initial begin
      bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_resp_inst = 0;
      bus.inst_ready = 0; bus.flush = 0; bus.flush_pc = 0;
      rst_n = 1'b0;
      model_reset();
      #2;
      chk("rst_req_valid", 32'(bus.mem_req_valid), 32'h0);
      chk("rst_addr", bus.mem_req_addr, ResetPc);
      chk("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
      chk("rst_inst", bus.inst, 32'h0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // Sequential fetch and first request
      drive(1, 0, 0, 0, 0, 0); chk("first_req", 32'(bus.mem_req_valid), 32'h1); tick();
      drive(1, 1, 32'hfd010113, 0, 0, 0); tick();
      drive(1, 0, 0, 1, 0, 0);
      chk("addi_inst", bus.inst, 32'hfd010113);
      chk("addi_next", bus.mem_req_addr, 32'h4);
      tick();
      drive(1, 1, 32'h02912223, 0, 0, 0); tick();
      drive(1, 0, 0, 1, 1, 32'h10a8); chk("flush_req_low", 32'(bus.mem_req_valid), 32'h0);
      tick();
      // Backward branches
      drive(1, 0, 0, 0, 0, 0); chk("redirect_addr", bus.mem_req_addr, 32'h10a8); tick();
      drive(1, 1, 32'hfe891ae3, 0, 0, 0); tick();
      drive(0, 0, 0, 1, 0, 0);
      chk("bne_pred", 32'(bus.pred_taken), 32'h1);
      chk("bne_next", bus.mem_req_addr, 32'h109c);
      tick();
      drive(1, 0, 0, 0, 1, 32'h1078); tick();
      drive(1, 0, 0, 0, 0, 0); tick();
      drive(1, 1, 32'hfd3a46e3, 0, 0, 0); tick();
      drive(1, 0, 0, 1, 0, 0); chk("blt_next", bus.mem_req_addr, 32'h1044); tick();
      // Forward branch, JALR, JAL
      drive(1, 1, 32'h00000463, 0, 0, 0); tick();
      drive(1, 0, 0, 1, 0, 0); chk("fwd_next", bus.mem_req_addr, 32'h1048); tick();
      drive(1, 1, 32'h000080e7, 0, 0, 0); tick();
      drive(1, 0, 0, 1, 0, 0); chk("jalr_next", bus.mem_req_addr, 32'h104c); tick();
      drive(1, 1, 32'h0080006f, 0, 0, 0); tick();
      drive(0, 0, 0, 1, 0, 0); chk("jal_next", bus.mem_req_addr, 32'h1054); tick();

      // Fill the queue
      drive(1, 0, 0, 0, 1, 32'h3000); tick();
      for (int i = 0; i < 8; i++) begin
         drive(1, 0, 0, 0, 0, 0); tick();
         drive(1, 1, 32'h00000013, 0, 0, 0); tick();
      end
      drive(1, 0, 0, 0, 0, 0); chk("full_req_low", 32'(bus.mem_req_valid), 32'h0); tick();
      drive(1, 0, 0, 1, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 0); chk("resume_req", 32'(bus.mem_req_valid), 32'h1); tick();
      drive(1, 1, 32'h00000013, 1, 0, 0); tick();

      // Flush while WAIT, late response dropped
      drive(1, 0, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 1, 32'h2000); tick();
      drive(1, 0, 0, 0, 0, 0); chk("flush_empty", 32'(bus.inst_valid), 32'h0); tick();
      drive(1, 1, 32'h02412483, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 0); chk("drop_next", bus.mem_req_addr, 32'h2000); tick();
      // Flush coincident with response
      drive(1, 1, 32'h00000013, 0, 1, 32'h2400); tick();
      drive(1, 0, 0, 0, 0, 0); chk("coinc_req", 32'(bus.mem_req_valid), 32'h1); tick();

      // Mid-operation reset with a request outstanding
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("midrst_req", 32'(bus.mem_req_valid), 32'h0);
      chk("midrst_addr", bus.mem_req_addr, ResetPc);
      @(negedge clk);
      rst_n = 1'b1;

      for (int c = 0; c < 2000; c++) begin
         bit resp = m_out && (resp_wait == 0);
         drive(($urandom % 4) != 0, resp, rand_inst(), ($urandom % 3) != 0,
               ($urandom % 25) == 0, $urandom & 32'hFFFF_FFFC);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/inst_fetcher.md
# inst_fetcher

Instruction fetch stage with a static branch predictor and a circular instruction queue. It sits directly upstream of the decode/dispatch path. It requests 32-bit instruction words from the memory interface one at a time and predicts the next PC. Fetched entries (inst, pc, pred_taken) are buffered for the dispatcher, which feeds `inst` into the Decoder. A flush from the commit side discards all queued and in-flight work and restarts fetch at a new PC.

## Interface
- IQ_DEPTH, 8, queue entries; power of two, ≥2
- RESET_PC, 32'h0, first fetch address after reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- mem_req_valid  out  1  fetch request valid
- mem_req_addr  out  32  fetch address (current PC register)
- mem_req_ready  in  1  memory accepts request this cycle
- mem_resp_valid  in  1  instruction word returned this cycle
- mem_resp_inst  in  32  returned instruction word
- inst_valid  out  1  queue head holds a valid entry
- inst  out  32  head instruction (to dispatcher/Decoder)
- inst_pc  out  32  head PC
- pred_taken  out  1  head predicted-taken flag
- inst_ready  in  1  dispatcher pops head this cycle
- flush  in  1  mispredict/redirect
- flush_pc  in  32  restart PC

## Operation
- **FSM states:**
  - FETCH: no request outstanding.
  - WAIT: one request outstanding, response wanted.
  - DROP: one request outstanding, response to be discarded.
- **Single outstanding request:** the memory returns exactly one mem_resp_valid per accepted request, in order.
- **FETCH:**
  - mem_req_valid = (count < IQ_DEPTH) && !flush.
  - On mem_req_valid && mem_req_ready, go to WAIT.
- **WAIT:**
  - On mem_resp_valid, push {mem_resp_inst, pc, pred}, set pc <= next_pc, go to FETCH.
  - Space for the push is guaranteed because the request was issued only when count < IQ_DEPTH.
- **DROP:** on mem_resp_valid, discard the word and go to FETCH.
- **Flush (highest priority):**
  - Queue cleared: head = tail = count = 0; any same-cycle pop or push is ignored.
  - pc <= flush_pc.
  - State: FETCH stays FETCH; WAIT goes to DROP; DROP stays DROP.
  - Exception: if mem_resp_valid arrives in the same cycle as a flush in WAIT or DROP, the word is discarded and the state goes to FETCH.
- **Prediction** (all sums mod 2^32):
  - JAL (opcode 1101111): next_pc = pc + sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}), pred = 1.
  - Branch (opcode 1100011): imm = sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}). Backward-taken rule: if inst[31] = 1 (negative offset), next_pc = pc + imm and pred = 1; otherwise next_pc = pc + 4 and pred = 0.
  - All others, including JALR: next_pc = pc + 4, pred = 0.
- **Queue:**
  - Circular buffer with head and tail of width log2(IQ_DEPTH), both wrapping modulo IQ_DEPTH.
  - count is log2(IQ_DEPTH)+1 bits.
  - Pop when inst_valid && inst_ready.
  - Push and pop in the same cycle leave count unchanged; this is legal at count == IQ_DEPTH (pop frees the slot).
  - inst_valid = (count != 0).
  - inst, inst_pc and pred_taken show the head entry and are driven 0 when inst_valid = 0.

## Timing
- **Reset (rst = 0), asynchronously:**
  - pc = RESET_PC, state = FETCH, head = tail = count = 0.
  - Outputs: mem_req_valid = 0, inst_valid = 0, inst = 0, inst_pc = 0, pred_taken = 0, mem_req_addr = RESET_PC.
- **Mid-operation reset** abandons any outstanding request. The bench must not return a response for it after release.
- **First request:** mem_req_valid = 1 in the first cycle after rst deasserts.
- **Latency:**
  - Request accepted at edge t; response at cycle t+k (k ≥ 1, memory-defined).
  - Entry visible at inst_valid in the cycle after the response edge.
  - Next request can be issued in that same cycle.
  - Best case: 1 instruction per 2 cycles at k = 1.
- **Flush timing:**
  - mem_req_valid is 0 in the flush cycle.
  - inst_valid = 0 in the cycle after flush.
  - A new request at flush_pc is issued in the cycle after flush if the state is FETCH; otherwise it follows the discarded response.
- **Queue full:** at count == IQ_DEPTH, mem_req_valid stays 0 until a pop.

## Test plan
- Reset then release, memory ready → cycle 1: mem_req_valid = 1, mem_req_addr = 0x0, inst_valid = 0.
- Sequential fetch at pc 0x0, response 0xfd010113 (addi) → head {0xfd010113, 0x0, pred 0}; next mem_req_addr = 0x4.
- Backward branch: pc 0x10a8, response 0xfe891ae3 (bne) → pred_taken = 1, next addr 0x109c. Repeat with pc 0x1078 and 0xfd3a46e3 (blt) → next addr 0x1044.
- Forward branch and JALR: 0x02912223-style non-branch and a forward branch → pred 0, next addr pc + 4.
- Full queue:
  - inst_ready = 0, 8 responses → count = 8, mem_req_valid = 0.
  - One pop → request resumes next cycle.
  - Push and pop in the same cycle → count unchanged.
- Flush while WAIT, flush_pc 0x2000:
  - Next cycle inst_valid = 0.
  - Late response 0x02412483 is dropped; next request addr 0x2000.
  - Also test flush coincident with mem_resp_valid → word dropped, state FETCH.
